lbdr_out_port_allocator: RTL

Per-output-port allocator for the mesh router. It shares one output port between the five input ports (N, E, W, S, L), each of which raises a request from its LBDR port-select bit. Grant is round-robin, taken only on a HEADER flit and held until that packet's TAIL flit is read. Reads are gated by a credit counter that tracks free slots in the downstream input buffer.

---
 rtl/lbdr_out_port_allocator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lbdr_out_port_allocator.sv
// Output-port allocator: round-robin arbitration among NREQ inputs on HEADER
// flits, lock held until the TAIL flit is popped, pops gated by a credit
// counter that mirrors free slots in the downstream input buffer.

`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b100
`endif

module lbdr_out_port_allocator #(
  parameter int NREQ    = 5,
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   valid,
  input  logic [3*NREQ-1:0] flit_id_bus,
  input  logic              credit_in,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   rd_en,
  output logic              out_valid,
  output logic [CW-1:0]     credit_cnt,
  output logic              busy,
  output logic              err_ovf
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] CREDITS_V = CW'(CREDITS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q;
  logic [NREQ-1:0] grant_q;
  logic            busy_q;
  logic [IW-1:0]   rr_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            err_q;

  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] tail_vec;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic            tail_pop;

  // Header candidates, tail detection and circular search after the last winner
  always_comb begin
    int unsigned idx;
    cand      = '0;
    tail_vec  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand[i]     = req[i] & valid[i] & (flit_id_bus[3*i +: 3] == `HEADER);
      tail_vec[i] = (flit_id_bus[3*i +: 3] == `TAIL);
    end
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(rr_q) + k) % 32'(NREQ);
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  // Pop strobe: only the locked input, only with a credit; suppressed while in reset
  always_comb begin
    rd_en = '0;
    if (state_q == LOCKED && cnt_q != '0 && !rst)
      rd_en = grant_q & valid;
    out_valid = |rd_en;
    tail_pop  = |(rd_en & tail_vec);
  end

  // Credit next-state: decrement on pop, increment on returned credit, saturate at CREDITS
  always_comb begin
    cnt_d = cnt_q;
    if (credit_in && !out_valid) begin
      if (cnt_q != CREDITS_V)
        cnt_d = cnt_q + CW'(1);
    end else if (!credit_in && out_valid) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Arbitration/lock FSM with registered grant and busy
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      rr_q    <= IW'(NREQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q <= LOCKED;
            grant_q <= NREQ'(1) << win_idx;
            busy_q  <= 1'b1;
            rr_q    <= win_idx;
          end else begin
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        LOCKED: begin
          if (tail_pop) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Credit counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CREDITS_V;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (credit_in && cnt_q == CREDITS_V)
        err_q <= 1'b1;
    end
  end

  assign grant      = grant_q;
  assign busy       = busy_q;
  assign credit_cnt = cnt_q;
  assign err_ovf    = err_q;

endmodule
